autopilot_controller: RTL
=========================

Name: autopilot_controller

Overview:
- Parametrised successor to the single-threshold AI player. Drives the start, up and down button inputs of the game core when no gamepad is present.
- Handles NUM_OBS obstacles, each tagged as ground or air. Jumps over ground obstacles for a fixed hold time and ducks under air obstacles.
- The trigger threshold scales with game speed.
- Automatically restarts after a crash or freeze with a periodic start pulse.
- Sits between gamepad_input and the game FSM; all decisions are taken on game_tick.

Parameters:
- NUM_OBS, 2: number of obstacle channels.
- POS_W, 10: obstacle x-position width in bits.
- SPEED_W, 4: game speed input width.
- PLAYER_OFFSET, 6: positions at or below this value are behind the player and are ignored.
- BASE_THRESHOLD, 40: trigger threshold at speed 0.
- SPEED_GAIN, 4: threshold increment per speed unit.
- JUMP_HOLD, 8: number of ticks button_up is held per jump (must be at least 1).
- RESTART_DELAY, 60: period in ticks of the start pulse while crashed or frozen (must be at least 1).
- COOLDOWN, 4: ticks during which a new jump is suppressed (optional feature only).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- game_tick  in  1  one-clk strobe per game frame.
- gamepad_is_present  in  1  selects pass-through mode.
- gamepad_start / gamepad_up / gamepad_down  in  1 each  human inputs.
- obs_pos  in  NUM_OBS*POS_W  packed positions; channel i occupies [i*POS_W +: POS_W].
- obs_valid  in  NUM_OBS  channel i holds a live obstacle.
- obs_air  in  NUM_OBS  1 = air obstacle (duck), 0 = ground obstacle (jump).
- speed  in  SPEED_W  current game speed.
- crash  in  1  player has collided.
- game_frozen  in  1  game halted.
- button_start / button_up / button_down  out  1 each  registered button outputs.

Behaviour:
- Reset: rst_n is synchronous and active-low; clock is clk.
  - Reset has priority over game_tick.
  - All outputs go to 0, state goes to RUN, all counters clear.
  - Reset asserted mid-jump or mid-restart aborts the operation immediately.
- Update timing: state and outputs update only on a clk edge where game_tick=1, and hold between ticks. Inputs are sampled on the same edge, so latency is 0 ticks from the sampled inputs to the registered outputs.
- Threshold: thr = BASE_THRESHOLD + speed*SPEED_GAIN.
  - Computed at POS_W+1 bits.
  - Saturates to 2^POS_W-1.
- Per-channel window: hit_i = obs_valid[i] && obs_pos_i > PLAYER_OFFSET && obs_pos_i <= thr.
- Aggregate hits: ground_hit = any hit_i with !obs_air[i]; air_hit = any hit_i with obs_air[i].
- Pass-through: when gamepad_is_present=1, outputs equal the gamepad inputs, state is forced to RUN and counters clear. This preempts any state. The controller resumes from RUN on the first tick after the gamepad is removed.
- FSM states: RUN, JUMP, DUCK, RESTART.
  - Global rule: crash|game_frozen in any non-RESTART state moves to RESTART; up and down go to 0, start goes to 0, rst_cnt goes to 0.
  - RUN, priority ground_hit > air_hit:
    - ground_hit: go to JUMP; up=1; hold_cnt=JUMP_HOLD-1.
    - air_hit: go to DUCK; down=1.
    - otherwise: all outputs 0.
  - JUMP: up stays 1 while hold_cnt>0, decrementing each tick. On a tick with hold_cnt==0: up=0, go to RUN. button_up is therefore high for exactly JUMP_HOLD ticks. New hits are ignored while in JUMP.
  - DUCK:
    - ground_hit: go to JUMP (down=0, up=1, hold_cnt reloaded).
    - else air_hit: down stays 1.
    - otherwise: down=0, go to RUN.
  - RESTART:
    - up and down stay 0.
    - If crash|game_frozen is still high: when rst_cnt==RESTART_DELAY-1, start=1 and rst_cnt=0; else rst_cnt+1 and start=0. The start pulse is one tick wide and repeats every RESTART_DELAY ticks; the first pulse comes RESTART_DELAY ticks after the entry tick.
    - If both are low: start=0, go to RUN.
- Simultaneous ground and air hits: jump wins.
- Channels with obs_valid=0 are ignored regardless of position.

Optional Feature:
- Macro: AUTOPILOT_COOLDOWN_EN.
- When defined: on a JUMP-to-RUN exit, a cooldown counter loads COOLDOWN. While it is non-zero it decrements each tick, and ground_hit is masked in RUN and DUCK (air_hit is not masked). Crash, pass-through and reset clear the counter.
- When undefined: the counter and the COOLDOWN parameter are unused; a jump can re-trigger on the first tick after exit.

Decomposition:
- Package autopilot_pkg holds:
  - the state enum (RUN, JUMP, DUCK, RESTART) with 2-bit encoding;
  - a threshold saturation function;
  - counter width constants computed as clog2(JUMP_HOLD+1) and clog2(RESTART_DELAY+1).
- Sub-module obstacle_window, instantiated NUM_OBS times in a generate loop: a combinational compare of one channel against thr and PLAYER_OFFSET, producing hit and air-qualified hit.

Test Plan:
- Reset: rst_n low for 2 clks with game_tick high and crash high -> all outputs 0, state RUN; first tick after release evaluates from RUN.
- Ground threshold edges, speed=0, single ground obstacle:
  - obs_pos=40 -> button_up high for exactly 8 ticks, then 0;
  - pos=41 or pos=6 -> no jump;
  - pos=7 -> jump;
  - obs_valid=0 at pos=20 -> no jump.
- Speed scaling:
  - speed=4 -> thr=56: pos=56 jumps, pos=57 does not.
  - POS_W=6, speed=15 -> thr saturates to 63 (no wrap): pos=63 jumps.
- Duck and preemption:
  - air obstacle stepping 30 down to 6 -> button_down high while pos in 7..30, low at pos=6.
  - ground obstacle at pos=20 on ch1 mid-duck -> down=0, up=1 on the same tick.
- Restart: crash held for 130 ticks -> start pulses one tick at ticks 60 and 120 after entry, up/down stay 0; crash released -> RUN on the next tick.
- Pass-through: gamepad_is_present raised mid-jump (tick 3 of 8) -> outputs mirror the gamepad on that tick, jump aborted; removed -> next tick evaluates from RUN.
- With AUTOPILOT_COOLDOWN_EN, COOLDOWN=4: second ground obstacle in window at jump exit -> no re-jump for 4 ticks, jump on the 5th.

Source files
------------

// File: rtl/autopilot_pkg.sv
// autopilot_pkg: shared types and helpers for the autopilot controller.
//   state_t         - controller state (RUN, JUMP, DUCK, RESTART), 2-bit encoding
//   cnt_width()     - width of a counter that must hold values 0..max_count
//   sat_threshold() - clamps a raw trigger threshold to the largest position value
//   DEF_*           - default hold and restart periods used by the top level
package autopilot_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    JUMP    = 2'd1,
    DUCK    = 2'd2,
    RESTART = 2'd3
  } state_t;

  localparam int DEF_JUMP_HOLD     = 8;
  localparam int DEF_RESTART_DELAY = 60;

  // clog2(max_count+1), never narrower than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  // Positions are pos_w bits wide, so any threshold above 2^pos_w-1 is
  // clamped rather than allowed to wrap into a tiny window.
  function automatic logic [31:0] sat_threshold(input logic [31:0] raw, input int pos_w);
    logic [31:0] max_v;
    max_v = (32'd1 << pos_w) - 32'd1;
    return (raw > max_v) ? max_v : raw;
  endfunction

endpackage

// File: rtl/autopilot_if.sv
// autopilot_if: game-side signals seen by the autopilot controller.
//   master - game/gamepad side: drives tick, gamepad, obstacle, speed and
//            crash/freeze inputs; receives the button outputs.
//   slave  - the controller.
//
// Handshake: there is no valid/ready pair. game_tick is a one-clk strobe;
// every other input is only sampled on a clk edge with game_tick=1, and the
// button outputs change only on such an edge and hold in between.
// obs_valid[i] qualifies channel i; obs_pos/obs_air of a channel with
// obs_valid[i]=0 are don't-care.
interface autopilot_if #(
  parameter int NUM_OBS = 2,
  parameter int POS_W   = 10,
  parameter int SPEED_W = 4
);
  logic                     game_tick;
  logic                     gamepad_is_present;
  logic                     gamepad_start;
  logic                     gamepad_up;
  logic                     gamepad_down;
  logic [NUM_OBS*POS_W-1:0] obs_pos;
  logic [NUM_OBS-1:0]       obs_valid;
  logic [NUM_OBS-1:0]       obs_air;
  logic [SPEED_W-1:0]       speed;
  logic                     crash;
  logic                     game_frozen;
  logic                     button_start;
  logic                     button_up;
  logic                     button_down;

  modport master (
    output game_tick, gamepad_is_present, gamepad_start, gamepad_up, gamepad_down,
    output obs_pos, obs_valid, obs_air, speed, crash, game_frozen,
    input  button_start, button_up, button_down
  );

  modport slave (
    input  game_tick, gamepad_is_present, gamepad_start, gamepad_up, gamepad_down,
    input  obs_pos, obs_valid, obs_air, speed, crash, game_frozen,
    output button_start, button_up, button_down
  );
endinterface

// File: rtl/obstacle_window.sv
// obstacle_window: combinational window test for one obstacle channel.
//   pos, valid, air - the channel's position, live flag and air/ground tag
//   thr             - current (already saturated) trigger threshold
//   hit             - live obstacle strictly ahead of the player and within thr
//   air_hit         - hit on an air obstacle
module obstacle_window #(
  parameter int POS_W         = 10,
  parameter int PLAYER_OFFSET = 6
) (
  input  logic [POS_W-1:0] pos,
  input  logic             valid,
  input  logic             air,
  input  logic [POS_W-1:0] thr,
  output logic             hit,
  output logic             air_hit
);

  assign hit     = valid && (pos > POS_W'(PLAYER_OFFSET)) && (pos <= thr);
  assign air_hit = hit && air;

endmodule

// File: rtl/autopilot_controller.sv
// autopilot_controller: drives start/up/down buttons of the game core when no
// gamepad is connected. Jumps over ground obstacles for JUMP_HOLD ticks, ducks
// under air obstacles, and pulses start every RESTART_DELAY ticks while the
// game is crashed or frozen. With a gamepad present the buttons mirror it.
//   clk, rst_n - clock, synchronous active-low reset
//   bus        - autopilot_if.slave (tick, gamepad, obstacles, speed, crash,
//                freeze in; button_start/up/down out, registered)
//   state_dbg  - current controller state
// Optional build macro: AUTOPILOT_COOLDOWN_EN - after a jump ends, ground
// obstacles are ignored for COOLDOWN ticks.
module autopilot_controller
  import autopilot_pkg::*;
#(
  parameter int NUM_OBS        = 2,
  parameter int POS_W          = 10,
  parameter int SPEED_W        = 4,
  parameter int PLAYER_OFFSET  = 6,
  parameter int BASE_THRESHOLD = 40,
  parameter int SPEED_GAIN     = 4,
  parameter int JUMP_HOLD      = DEF_JUMP_HOLD,
  parameter int RESTART_DELAY  = DEF_RESTART_DELAY,
  parameter int COOLDOWN       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  autopilot_if.slave  bus,
  output state_t      state_dbg
);

  localparam int HOLD_W = cnt_width(JUMP_HOLD);
  localparam int RST_W  = cnt_width(RESTART_DELAY);

  if (JUMP_HOLD < 1 || RESTART_DELAY < 1 || COOLDOWN < 0) begin : g_bad_params
    $error("autopilot_controller: JUMP_HOLD and RESTART_DELAY must be >= 1, COOLDOWN >= 0");
  end

  // Threshold grows with speed; computed wide, then clamped to the position range.
  logic [31:0]      thr_raw;
  logic [POS_W-1:0] thr;

  assign thr_raw = 32'(BASE_THRESHOLD) + 32'(bus.speed) * 32'(SPEED_GAIN);
  assign thr     = POS_W'(sat_threshold(thr_raw, POS_W));

  logic [NUM_OBS-1:0] hit_v;
  logic [NUM_OBS-1:0] air_hit_v;

  for (genvar i = 0; i < NUM_OBS; i++) begin : g_win
    obstacle_window #(
      .POS_W         (POS_W),
      .PLAYER_OFFSET (PLAYER_OFFSET)
    ) u_win (
      .pos     (bus.obs_pos[i*POS_W +: POS_W]),
      .valid   (bus.obs_valid[i]),
      .air     (bus.obs_air[i]),
      .thr     (thr),
      .hit     (hit_v[i]),
      .air_hit (air_hit_v[i])
    );
  end

  logic ground_hit;
  logic air_hit;
  logic ground_go;
  logic halt;

  assign ground_hit = |(hit_v & ~air_hit_v);
  assign air_hit    = |air_hit_v;
  assign halt       = bus.crash | bus.game_frozen;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [RST_W-1:0]  rst_cnt;
  logic              up_q;
  logic              down_q;
  logic              start_q;

`ifdef AUTOPILOT_COOLDOWN_EN
  localparam int COOL_W = cnt_width(COOLDOWN);
  logic [COOL_W-1:0] cool_cnt;

  // Loaded on the tick a jump ends; ground hits stay masked until it drains.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cool_cnt <= '0;
    end else if (bus.game_tick) begin
      if (bus.gamepad_is_present || (halt && state != RESTART)) begin
        cool_cnt <= '0;
      end else if (state == JUMP && hold_cnt == '0) begin
        cool_cnt <= COOL_W'(COOLDOWN);
      end else if (cool_cnt != '0) begin
        cool_cnt <= cool_cnt - COOL_W'(1);
      end
    end
  end

  assign ground_go = ground_hit && (cool_cnt == '0);
`else
  assign ground_go = ground_hit;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      hold_cnt <= '0;
      rst_cnt  <= '0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      start_q  <= 1'b0;
    end else if (bus.game_tick) begin
      if (bus.gamepad_is_present) begin
        // Human in control: mirror the pad, park the FSM in RUN.
        state    <= RUN;
        hold_cnt <= '0;
        rst_cnt  <= '0;
        up_q     <= bus.gamepad_up;
        down_q   <= bus.gamepad_down;
        start_q  <= bus.gamepad_start;
      end else if (halt && state != RESTART) begin
        state    <= RESTART;
        hold_cnt <= '0;
        rst_cnt  <= '0;
        up_q     <= 1'b0;
        down_q   <= 1'b0;
        start_q  <= 1'b0;
      end else begin
        unique case (state)
          RUN: begin
            start_q <= 1'b0;
            if (ground_go) begin
              state    <= JUMP;
              up_q     <= 1'b1;
              down_q   <= 1'b0;
              hold_cnt <= HOLD_W'(JUMP_HOLD - 1);
            end else if (air_hit) begin
              state  <= DUCK;
              up_q   <= 1'b0;
              down_q <= 1'b1;
            end else begin
              up_q   <= 1'b0;
              down_q <= 1'b0;
            end
          end
          JUMP: begin
            // Entry tick already counted as the first of JUMP_HOLD high ticks.
            down_q  <= 1'b0;
            start_q <= 1'b0;
            if (hold_cnt != '0) begin
              up_q     <= 1'b1;
              hold_cnt <= hold_cnt - HOLD_W'(1);
            end else begin
              up_q  <= 1'b0;
              state <= RUN;
            end
          end
          DUCK: begin
            start_q <= 1'b0;
            if (ground_go) begin
              state    <= JUMP;
              up_q     <= 1'b1;
              down_q   <= 1'b0;
              hold_cnt <= HOLD_W'(JUMP_HOLD - 1);
            end else if (air_hit) begin
              up_q   <= 1'b0;
              down_q <= 1'b1;
            end else begin
              up_q   <= 1'b0;
              down_q <= 1'b0;
              state  <= RUN;
            end
          end
          RESTART: begin
            up_q   <= 1'b0;
            down_q <= 1'b0;
            if (halt) begin
              if (rst_cnt == RST_W'(RESTART_DELAY - 1)) begin
                start_q <= 1'b1;
                rst_cnt <= '0;
              end else begin
                start_q <= 1'b0;
                rst_cnt <= rst_cnt + RST_W'(1);
              end
            end else begin
              start_q <= 1'b0;
              rst_cnt <= '0;
              state   <= RUN;
            end
          end
          default: begin
            state <= RUN;
          end
        endcase
      end
    end
  end

  assign bus.button_up    = up_q;
  assign bus.button_down  = down_q;
  assign bus.button_start = start_q;
  assign state_dbg        = state;

endmodule
